// File: rtl/ladybird_aclint.sv
// ACLINT responder (MSWI/MTIMER/SSWI) for the ladybird hart; response one cycle after accept, one request in flight.
// Optional LADYBIRD_ACLINT_MTIME_LATCH_EN: MTIME lo read shadows mtime[63:32] for a tear-free hi read.
module ladybird_aclint #(
    parameter logic [31:0] BASEADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        mtip,
    output logic        msip,
    output logic        ssip_set
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_SETSSIP  = 16'h8000;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    logic [0:0]  state_q, state_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q, presc_d;
    logic        msip_q, msip_d, ssip_q, ssip_d, mtip_q;
    logic [15:0] off;
    logic        is_wr, tick;
    logic [63:0] mtime_inc;
    logic [31:0] rdata;
    logic        unused_addr_bits;
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
    logic [31:0] shadow_q, shadow_d;
    logic        shadow_vld_q, shadow_vld_d;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    assign unused_addr_bits = ^req_addr[31:16];
    assign off       = (req_addr[15:0] - BASEADDR[15:0]) & 16'hFFFC;
    assign is_wr     = (req_strb != 4'b0000);
    assign tick      = (presc_q == 16'(TICK_DIV - 1));
    assign presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    assign mtime_inc = mtime_q + {63'd0, tick};

    always_comb begin
        rdata = 32'd0;
        case (off)
            OFF_MSIP:     rdata = {31'd0, msip_q};
            OFF_CMP_LO:   rdata = mtimecmp_q[31:0];
            OFF_CMP_HI:   rdata = mtimecmp_q[63:32];
            OFF_MTIME_LO: rdata = mtime_q[31:0];
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
            OFF_MTIME_HI: rdata = shadow_vld_q ? shadow_q : mtime_q[63:32];
`else
            OFF_MTIME_HI: rdata = mtime_q[63:32];
`endif
            default:      rdata = 32'd0;
        endcase
    end

    // MTIME writes merge into the ticked value so unwritten bytes keep the carry from the old value.
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        mtime_d     = mtime_inc;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        ssip_d      = 1'b0;
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
`endif
        if (state_q == S_IDLE) begin
            if (req_valid) begin
                state_d     = S_RESP;
                resp_data_d = is_wr ? 32'd0 : rdata;
                if (is_wr) begin
                    case (off)
                        OFF_MSIP:     if (req_strb[0]) msip_d = req_wdata[0];
                        OFF_CMP_LO:   mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], req_wdata, req_strb);
                        OFF_CMP_HI:   mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], req_wdata, req_strb);
                        OFF_SETSSIP:  ssip_d = req_wdata[0] & req_strb[0];
                        OFF_MTIME_LO: begin
                            mtime_d[31:0] = merge(mtime_inc[31:0], req_wdata, req_strb);
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
                            shadow_d     = 32'd0;
                            shadow_vld_d = 1'b0;
`endif
                        end
                        OFF_MTIME_HI: begin
                            mtime_d[63:32] = merge(mtime_inc[63:32], req_wdata, req_strb);
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
                            shadow_d     = 32'd0;
                            shadow_vld_d = 1'b0;
`endif
                        end
                        default: ;
                    endcase
                end
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
                else if (off == OFF_MTIME_LO) begin
                    shadow_d     = mtime_q[63:32];
                    shadow_vld_d = 1'b1;
                end else if (off == OFF_MTIME_HI) begin
                    shadow_vld_d = 1'b0;
                end
`endif
            end
        end else if (resp_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            resp_data_q <= 32'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q     <= 16'd0;
            msip_q      <= 1'b0;
            ssip_q      <= 1'b0;
            mtip_q      <= 1'b0;
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
            shadow_q     <= 32'd0;
            shadow_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_q     <= presc_d;
            msip_q      <= msip_d;
            ssip_q      <= ssip_d;
            mtip_q      <= (mtime_q >= mtimecmp_q);
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;
    assign mtip       = mtip_q;
    assign msip       = msip_q;
    assign ssip_set   = ssip_q;
endmodule

// File: tb/tb_ladybird_aclint.sv
// Bench for ladybird_aclint: two instances (TICK_DIV 1 and 4) share stimulus and are checked each cycle against a model.
module tb_ladybird_aclint;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_strb = 4'd0;
    logic        rr [2];
    logic        rv [2];
    logic        mtip [2];
    logic        msip [2];
    logic        ss [2];
    logic [31:0] rd [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ladybird_aclint #(.BASEADDR(BASE), .TICK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr[0]),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_data(rd[0]),
        .mtip(mtip[0]), .msip(msip[0]), .ssip_set(ss[0]));

    ladybird_aclint #(.BASEADDR(BASE), .TICK_DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr[1]),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_data(rd[1]),
        .mtip(mtip[1]), .msip(msip[1]), .ssip_set(ss[1]));

    task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", nm, idx, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mt [2];
    logic [63:0] m_cmp [2];
    logic        m_msip [2];
    logic        m_mtip [2];
    logic        m_busy [2];
    logic        m_ssip [2];
    logic [31:0] m_rd [2];
    logic [31:0] m_sh [2];
    logic        m_shv [2];
    int unsigned m_cyc [2];
    logic [63:0] t_mt;
    logic [15:0] t_off;
    bit          model_ok = 1'b0;

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input int i, input logic [15:0] o);
        case (o)
            16'h0000: return {31'd0, m_msip[i]};
            16'h4000: return m_cmp[i][31:0];
            16'h4004: return m_cmp[i][63:32];
            16'hBFF8: return m_mt[i][31:0];
`ifdef LADYBIRD_ACLINT_MTIME_LATCH_EN
            16'hBFFC: return m_shv[i] ? m_sh[i] : m_mt[i][63:32];
`else
            16'hBFFC: return m_mt[i][63:32];
`endif
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_mt[i] = 64'd0; m_cmp[i] = '1; m_msip[i] = 1'b0; m_mtip[i] = 1'b0;
                m_busy[i] = 1'b0; m_ssip[i] = 1'b0; m_rd[i] = 32'd0; m_cyc[i] = 0;
                m_sh[i] = 32'd0; m_shv[i] = 1'b0;
                model_ok = 1'b1;
            end else begin
                // mtime advances on every div-th cycle counted from reset
                t_mt = m_mt[i] + (((m_cyc[i] % div_of(i)) == div_of(i) - 1) ? 64'd1 : 64'd0);
                m_cyc[i]++;
                m_mtip[i] = (m_mt[i] >= m_cmp[i]);
                m_ssip[i] = 1'b0;
                if (!m_busy[i] && req_valid) begin
                    t_off = (req_addr[15:0] - BASE[15:0]) & 16'hFFFC;
                    if (req_strb == 4'd0) begin
                        m_rd[i] = mread(i, t_off);
                        if (t_off == 16'hBFF8) begin m_sh[i] = m_mt[i][63:32]; m_shv[i] = 1'b1; end
                        if (t_off == 16'hBFFC) m_shv[i] = 1'b0;
                    end else begin
                        m_rd[i] = 32'd0;
                        case (t_off)
                            16'h0000: if (req_strb[0]) m_msip[i] = req_wdata[0];
                            16'h4000: m_cmp[i][31:0]  = mrg(m_cmp[i][31:0], req_wdata, req_strb);
                            16'h4004: m_cmp[i][63:32] = mrg(m_cmp[i][63:32], req_wdata, req_strb);
                            16'h8000: m_ssip[i] = req_wdata[0] & req_strb[0];
                            16'hBFF8: begin t_mt[31:0]  = mrg(t_mt[31:0], req_wdata, req_strb);  m_sh[i] = 0; m_shv[i] = 0; end
                            16'hBFFC: begin t_mt[63:32] = mrg(t_mt[63:32], req_wdata, req_strb); m_sh[i] = 0; m_shv[i] = 0; end
                            default: ;
                        endcase
                    end
                    m_busy[i] = 1'b1;
                end else if (m_busy[i] && resp_ready) begin
                    m_busy[i] = 1'b0;
                end
                m_mt[i] = t_mt;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                check("req_ready", i, {63'd0, rr[i]}, {63'd0, !m_busy[i]});
                check("resp_valid", i, {63'd0, rv[i]}, {63'd0, m_busy[i]});
                check("resp_data", i, {32'd0, rd[i]}, {32'd0, m_rd[i]});
                check("mtip", i, {63'd0, mtip[i]}, {63'd0, m_mtip[i]});
                check("msip", i, {63'd0, msip[i]}, {63'd0, m_msip[i]});
                check("ssip_set", i, {63'd0, ss[i]}, {63'd0, m_ssip[i]});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic xfer(input logic [15:0] o, input logic [31:0] w, input logic [3:0] s,
                        output logic [31:0] r0, output logic [31:0] r1, output logic ss0);
        int n;
        req_addr = BASE + {16'd0, o}; req_wdata = w; req_strb = s; req_valid = 1'b1;
        n = 0;
        while (!rr[0] && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("accept_timeout", 0, 64'd1, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        r0 = rd[0]; r1 = rd[1]; ss0 = ss[0];
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    logic [31:0] r0, r1;
    logic        s0;
    int          n;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", i, {63'd0, rr[i]}, 64'd1);
            check("rst_resp_valid", i, {63'd0, rv[i]}, 64'd0);
            check("rst_resp_data", i, {32'd0, rd[i]}, 64'd0);
            check("rst_mtip", i, {63'd0, mtip[i]}, 64'd0);
        end
        repeat (10) @(negedge clk);
        xfer(16'hBFF8, 32'd0, 4'd0, r0, r1, s0);
        check("mtime_lo_div1", 0, {32'd0, r0}, 64'd10);
        check("mtime_lo_div4", 1, {32'd0, r1}, 64'd2);
        xfer(16'h4000, 32'd0, 4'd0, r0, r1, s0);
        check("cmp_lo_rst", 0, {32'd0, r0}, 64'hFFFF_FFFF);
        xfer(16'h4004, 32'd0, 4'd0, r0, r1, s0);
        check("cmp_hi_rst", 0, {32'd0, r0}, 64'hFFFF_FFFF);
        check("mtip_before_cmp", 0, {63'd0, mtip[0]}, 64'd0);

        xfer(16'h4004, 32'd0, 4'hF, r0, r1, s0);
        xfer(16'h4000, 32'h20, 4'hF, r0, r1, s0);
        n = 0;
        while (!mtip[0] && n < 100) begin @(negedge clk); n++; end
        check("mtip_rise", 0, {63'd0, mtip[0]}, 64'd1);
        xfer(16'h4000, 32'hFFFF_FFFF, 4'hF, r0, r1, s0);
        check("mtip_fall", 0, {63'd0, mtip[0]}, 64'd0);

        xfer(16'h0000, 32'h1, 4'b0001, r0, r1, s0);
        check("msip_set", 0, {63'd0, msip[0]}, 64'd1);
        xfer(16'h0000, 32'd0, 4'd0, r0, r1, s0);
        check("msip_read", 0, {32'd0, r0}, 64'd1);
        xfer(16'h0000, 32'hFFFF_FFFE, 4'hF, r0, r1, s0);
        check("msip_clr", 0, {63'd0, msip[0]}, 64'd0);
        xfer(16'h8000, 32'h1, 4'hF, r0, r1, s0);
        check("ssip_pulse", 0, {63'd0, s0}, 64'd1);
        check("ssip_one_cycle", 0, {63'd0, ss[0]}, 64'd0);
        xfer(16'h8000, 32'd0, 4'd0, r0, r1, s0);
        check("setssip_read", 0, {32'd0, r0}, 64'd0);

        xfer(16'h4000, 32'd0, 4'hF, r0, r1, s0);
        xfer(16'h4004, 32'd0, 4'hF, r0, r1, s0);
        xfer(16'hBFF8, 32'hFFFF_FFFE, 4'hF, r0, r1, s0);
        xfer(16'hBFFC, 32'hFFFF_FFFF, 4'hF, r0, r1, s0);
        repeat (12) @(negedge clk);
        xfer(16'hBFFC, 32'd0, 4'd0, r0, r1, s0);
        check("mtime_wrap_hi_div4", 1, {32'd0, r1}, 64'd0);
        check("mtip_cmp0_div4", 1, {63'd0, mtip[1]}, 64'd1);

        // stalled response, second request offered, reset mid-response
        xfer(16'h0000, 32'h1, 4'b0001, r0, r1, s0);
        req_addr = BASE; req_strb = 4'd0; req_valid = 1'b1;
        @(negedge clk);
        req_addr = BASE + 32'h4000;
        for (int c = 0; c < 3; c++) begin
            check("stall_resp_valid", c, {63'd0, rv[0]}, 64'd1);
            check("stall_resp_data", c, {32'd0, rd[0]}, 64'd1);
            check("stall_req_ready", c, {63'd0, rr[0]}, 64'd0);
            if (c < 2) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("reset_drops_resp", 0, {63'd0, rv[0]}, 64'd0);
        reset = 1'b0; req_valid = 1'b0;

        // randomized traffic
        repeat (3000) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 399) == 0);
            req_valid  = $urandom_range(0, 1) == 1;
            resp_ready = $urandom_range(0, 3) != 0;
            req_wdata  = $urandom;
            req_strb   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            case ($urandom_range(0, 7))
                0: t_off = 16'h0000;
                1: t_off = 16'h4000;
                2: t_off = 16'h4004;
                3: t_off = 16'h8000;
                4: t_off = 16'hBFF8;
                5: t_off = 16'hBFFC;
                6: t_off = 16'($urandom);
                default: t_off = 16'hBFF8;
            endcase
            req_addr = {16'($urandom), BASE[15:0] + (t_off & 16'hFFFC) + 16'($urandom_range(0, 3))};
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1; reset = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
